// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the MAR/MDR side and mem_responder.
// master = CPU-side requester, slave = responder.
interface mem_responder_if #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, fixed wait states on the RAM
// port, range-checked addresses, read data / write ack returned on the rsp side.
module mem_responder #(
   parameter int unsigned       ADDR_W      = 13,
   parameter int unsigned       DATA_W      = 16,
   parameter logic [ADDR_W-1:0] ADDR_MAX    = 'h17FF,
   parameter int unsigned       WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   mem_responder_if.slave    bus,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       txn_count
);

   localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic              we_q;
   logic              err_q;
   logic [3:0]        wait_cnt;
   logic [DATA_W-1:0] rdata_q;
   logic              addr_err;
   logic              accept;
   logic              last_wait;
   logic              resp_done;
   logic              req_ready_c;
   logic              rsp_valid_c;
   logic              mem_en_c;

   assign addr_err = (bus.req_addr > ADDR_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      req_ready_c = 1'b0;
      rsp_valid_c = 1'b0;
      mem_en_c    = 1'b0;
      accept      = 1'b0;
      last_wait   = 1'b0;
      resp_done   = 1'b0;
      case (state)
         IDLE: begin
            req_ready_c = 1'b1;
            if (bus.req_valid) begin
               accept    = 1'b1;
               state_nxt = addr_err ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            mem_en_c  = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (wait_cnt == 4'd1) begin
               last_wait = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid_c = 1'b1;
            if (bus.rsp_ready) begin
               resp_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes decode straight from the state so an async reset drops them at once.
   assign mem_en        = mem_en_c;
   assign mem_we        = mem_en_c & we_q;
   assign bus.req_ready = req_ready_c;
   assign bus.rsp_valid = rsp_valid_c;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         wait_cnt  <= '0;
         rdata_q   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         txn_count <= '0;
      end else begin
         if (accept) begin
            err_q <= addr_err;
            we_q  <= bus.req_we;
            if (addr_err) begin
               rdata_q <= '0;
            end else begin
               // Only in-range requests touch the RAM-side address/data registers.
               mem_addr  <= bus.req_addr;
               mem_wdata <= bus.req_wdata;
            end
         end

         if (mem_en_c)
            wait_cnt <= WS_LOAD;
         else if (state == WAIT)
            wait_cnt <= wait_cnt - 4'd1;

         if (last_wait)
            rdata_q <= we_q ? '0 : mem_rdata;

         if (resp_done && !err_q)
            txn_count <= txn_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with 1 wait state, one with 4,
// each backed by a small behavioural RAM.
module tb_mem_responder;

   logic        clk;
   logic        rst;

   mem_responder_if #(.ADDR_W(13), .DATA_W(16)) if1 ();
   mem_responder_if #(.ADDR_W(13), .DATA_W(16)) if2 ();

   logic        mem_en1, mem_we1, mem_en2, mem_we2;
   logic [12:0] mem_addr1, mem_addr2;
   logic [15:0] mem_wdata1, mem_wdata2, mem_rdata1, mem_rdata2;
   logic [15:0] txn1, txn2;

   int vectors     = 0;
   int miscompares = 0;

   mem_responder #(.ADDR_W(13), .DATA_W(16), .ADDR_MAX(13'h17FF), .WAIT_STATES(1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(if1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1), .txn_count(txn1)
   );

   mem_responder #(.ADDR_W(13), .DATA_W(16), .ADDR_MAX(13'h17FF), .WAIT_STATES(4)) u_dut2 (
      .clk(clk), .rst(rst), .bus(if2),
      .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .mem_rdata(mem_rdata2), .txn_count(txn2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM 1: data valid the cycle after mem_en.
   logic [15:0] mem1 [0:8191];
   always @(posedge clk) begin
      if (!rst) begin
         mem1[13'h0040] <= 16'hBEEF;
         mem1[13'h17FF] <= 16'h5A5A;
      end else if (mem_en1) begin
         if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
         else         mem_rdata1      <= mem1[mem_addr1];
      end
   end

   // RAM 2: read data valid only in the 4th cycle after mem_en, junk otherwise.
   logic [15:0] mem2 [0:8191];
   logic [3:0]  sh2;
   logic [12:0] ra2;
   always @(posedge clk) begin
      if (!rst) begin
         sh2            <= '0;
         ra2            <= '0;
         mem2[13'h0040] <= 16'hCAFE;
      end else begin
         sh2 <= {sh2[2:0], mem_en2 & ~mem_we2};
         if (mem_en2) begin
            if (mem_we2) mem2[mem_addr2] <= mem_wdata2;
            else         ra2             <= mem_addr2;
         end
      end
   end
   assign mem_rdata2 = sh2[3] ? mem2[ra2] : 16'hDEAD;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input bit v, input bit we,
                        input logic [12:0] a, input logic [15:0] wd);
      if (sel) begin
         if2.req_valid = v; if2.req_we = we; if2.req_addr = a; if2.req_wdata = wd;
      end else begin
         if1.req_valid = v; if1.req_we = we; if1.req_addr = a; if1.req_wdata = wd;
      end
   endtask

   // Issue one request at the current negedge (cycle 0) and trace it, rsp_ready high.
   task automatic run(input bit sel, input bit we, input logic [12:0] a, input logic [15:0] wd,
                      output int en_cyc, output int en_cnt, output bit we_seen,
                      output int rsp_cyc, output logic [15:0] rd, output logic er);
      en_cyc = -1; en_cnt = 0; we_seen = 1'b0; rsp_cyc = -1; rd = 'x; er = 1'bx;
      drive(sel, 1'b1, we, a, wd);
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, '0, '0);
      for (int c = 1; c <= 30; c++) begin
         if (sel ? mem_en2 : mem_en1) begin
            en_cnt++;
            if (en_cyc < 0) begin
               en_cyc  = c;
               we_seen = sel ? mem_we2 : mem_we1;
            end
         end
         if (sel ? if2.rsp_valid : if1.rsp_valid) begin
            rsp_cyc = c;
            rd      = sel ? if2.rsp_rdata : if1.rsp_rdata;
            er      = sel ? if2.rsp_err : if1.rsp_err;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   int          en_cyc, en_cnt, rsp_cyc, seen;
   bit          we_seen;
   logic [15:0] rd;
   logic        er;

   initial begin
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      if1.rsp_ready = 1'b1;
      if2.rsp_ready = 1'b1;
      repeat (2) @(negedge clk);

      chk("rst_req_ready", if1.req_ready, 1);
      chk("rst_rsp_valid", if1.rsp_valid, 0);
      chk("rst_rsp_rdata", if1.rsp_rdata, 0);
      chk("rst_rsp_err",   if1.rsp_err, 0);
      chk("rst_mem_en",    mem_en1, 0);
      chk("rst_mem_we",    mem_we1, 0);
      chk("rst_mem_addr",  mem_addr1, 0);
      chk("rst_mem_wdata", mem_wdata1, 0);
      chk("rst_txn",       txn1, 0);
      rst = 1'b1;

      // Read 0x0040, 1 wait state
      run(1'b0, 1'b0, 13'h0040, 16'h0, en_cyc, en_cnt, we_seen, rsp_cyc, rd, er);
      chk("rd_en_cyc", en_cyc, 1);
      chk("rd_en_cnt", en_cnt, 1);
      chk("rd_we",     we_seen, 0);
      chk("rd_rsp_cyc", rsp_cyc, 3);
      chk("rd_data",   rd, 16'hBEEF);
      chk("rd_err",    er, 0);
      chk("rd_txn",    txn1, 1);

      // Write then read back
      run(1'b0, 1'b1, 13'h0100, 16'h1234, en_cyc, en_cnt, we_seen, rsp_cyc, rd, er);
      chk("wr_en_cyc", en_cyc, 1);
      chk("wr_we",     we_seen, 1);
      chk("wr_rsp_cyc", rsp_cyc, 3);
      chk("wr_data",   rd, 0);
      chk("wr_err",    er, 0);
      chk("wr_addr",   mem_addr1, 13'h0100);
      chk("wr_wdata",  mem_wdata1, 16'h1234);
      run(1'b0, 1'b0, 13'h0100, 16'h0, en_cyc, en_cnt, we_seen, rsp_cyc, rd, er);
      chk("rb_data",   rd, 16'h1234);
      chk("rb_txn",    txn1, 3);

      // Out of range, one past ADDR_MAX
      run(1'b0, 1'b0, 13'h1800, 16'h0, en_cyc, en_cnt, we_seen, rsp_cyc, rd, er);
      chk("oor_en_cnt", en_cnt, 0);
      chk("oor_rsp_cyc", rsp_cyc, 1);
      chk("oor_err",   er, 1);
      chk("oor_data",  rd, 0);
      chk("oor_txn",   txn1, 3);
      chk("oor_addr_held", mem_addr1, 13'h0100);

      // Exactly ADDR_MAX is legal
      run(1'b0, 1'b0, 13'h17FF, 16'h0, en_cyc, en_cnt, we_seen, rsp_cyc, rd, er);
      chk("max_en_cnt", en_cnt, 1);
      chk("max_err",   er, 0);
      chk("max_data",  rd, 16'h5A5A);
      chk("max_txn",   txn1, 4);

      // Backpressure with a competing request
      if1.rsp_ready = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 13'h0040, 16'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         if (if1.rsp_valid) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      chk("bp_rsp_seen", seen, 1);
      drive(1'b0, 1'b1, 1'b0, 13'h0100, 16'h0);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid",     if1.rsp_valid, 1);
         chk("bp_data",      if1.rsp_rdata, 16'hBEEF);
         chk("bp_err",       if1.rsp_err, 0);
         chk("bp_req_ready", if1.req_ready, 0);
         chk("bp_mem_en",    mem_en1, 0);
         @(negedge clk);
      end
      if1.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_after_valid", if1.rsp_valid, 0);
      chk("bp_after_ready", if1.req_ready, 1);
      chk("bp_after_en",    mem_en1, 0);
      chk("bp_txn",         txn1, 5);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      chk("bp2_en",   mem_en1, 1);
      chk("bp2_addr", mem_addr1, 13'h0100);
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         if (if1.rsp_valid) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      chk("bp2_rsp_seen", seen, 1);
      chk("bp2_data", if1.rsp_rdata, 16'h1234);
      @(negedge clk);
      chk("bp2_txn",  txn1, 6);

      // 4 wait states
      run(1'b1, 1'b0, 13'h0040, 16'h0, en_cyc, en_cnt, we_seen, rsp_cyc, rd, er);
      chk("ws4_en_cyc", en_cyc, 1);
      chk("ws4_rsp_cyc", rsp_cyc, 6);
      chk("ws4_data",  rd, 16'hCAFE);
      chk("ws4_err",   er, 0);
      chk("ws4_txn",   txn2, 1);
      run(1'b1, 1'b1, 13'h0200, 16'h7777, en_cyc, en_cnt, we_seen, rsp_cyc, rd, er);
      chk("ws4_wr_rsp_cyc", rsp_cyc, 6);
      chk("ws4_wr_data", rd, 0);
      run(1'b1, 1'b0, 13'h0200, 16'h0, en_cyc, en_cnt, we_seen, rsp_cyc, rd, er);
      chk("ws4_rb_data", rd, 16'h7777);
      chk("ws4_rb_txn",  txn2, 3);

      // Reset during ACCESS of a write
      drive(1'b0, 1'b1, 1'b1, 13'h0300, 16'hAAAA);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      chk("mr_en_before", mem_en1, 1);
      chk("mr_we_before", mem_we1, 1);
      #1 rst = 1'b0;
      #1;
      chk("mr_en_async",  mem_en1, 0);
      chk("mr_we_async",  mem_we1, 0);
      chk("mr_req_ready", if1.req_ready, 1);
      chk("mr_txn_clr",   txn1, 0);
      chk("mr_addr_clr",  mem_addr1, 0);
      @(negedge clk);
      rst  = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (if1.rsp_valid || mem_en1) seen++;
         @(negedge clk);
      end
      chk("mr_no_rsp",    seen, 0);
      chk("mr_ready_after", if1.req_ready, 1);
      chk("mr_txn_after", txn1, 0);
      run(1'b0, 1'b0, 13'h0040, 16'h0, en_cyc, en_cnt, we_seen, rsp_cyc, rd, er);
      chk("mr_rd_rsp_cyc", rsp_cyc, 3);
      chk("mr_rd_data",  rd, 16'hBEEF);
      chk("mr_rd_txn",   txn1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
